// File: rtl/clk_div_by_3.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_by_3
// Description : Divide-by-3 clock generator. A rising-edge mod-3 counter sets
//               a one-period pulse; an optional falling-edge retiming flop
//               stretches it to a 50% duty output.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_by_3 #(
    parameter int unsigned DUTY_50 = 1
) (
    input  logic clk_i,
    input  logic rst,
    output logic clk_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       p_q;
    logic       p_d;

    // The unreachable value 3 folds back to 0 together with the wrap from 2.
    always_comb begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q >= 2'd2) begin
            cnt_d = 2'd0;
        end
        p_d = (cnt_q == 2'd0);
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            p_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    generate
        if (DUTY_50 != 0) begin : g_duty_50
            logic n_q;
            logic n_d;

            always_comb begin
                n_d = p_q;
            end

            // p moves only on rising edges and n only on falling edges, so
            // the OR below never sees both inputs toggle at the same instant.
            always_ff @(negedge clk_i or negedge rst) begin
                if (!rst) begin
                    n_q <= 1'b0;
                end else begin
                    n_q <= n_d;
                end
            end

            assign clk_o = p_q | n_q;
        end else begin : g_duty_33
            assign clk_o = p_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_by_3.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_by_3
// Description : Self-checking bench for both duty variants of clk_div_by_3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_by_3;

    logic clk;
    logic clk_run;
    logic rst;
    logic clk_o50;
    logic clk_o33;

    int tests;
    int fails;

    clk_div_by_3 #(.DUTY_50(1)) u_dut50 (.clk_i(clk), .rst(rst), .clk_o(clk_o50));
    clk_div_by_3 #(.DUTY_50(0)) u_dut33 (.clk_i(clk), .rst(rst), .clk_o(clk_o33));

    // 2 ns input clock; edges land on whole nanoseconds, checks on x.5 ns.
    initial begin
        clk     = 1'b0;
        clk_run = 1'b1;
    end
    always begin
        #1;
        if (clk_run) clk = ~clk;
    end

    // Reference: count clock half-edges from the first rising edge after
    // release. Output is high for half-edges 0..2 (50%) or 0..1 (1/3) of 6.
    logic       m_started;
    int         m_j;
    always @(posedge clk or negedge clk or negedge rst) begin
        if (!rst) begin
            m_started <= 1'b0;
            m_j       <= 0;
        end else if (!m_started) begin
            if (clk) begin
                m_started <= 1'b1;
                m_j       <= 0;
            end
        end else begin
            m_j <= (m_j + 1) % 6;
        end
    end

    function automatic logic exp50();
        return m_started && (m_j < 3);
    endfunction
    function automatic logic exp33();
        return m_started && (m_j < 2);
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step_model(input string name);
        #1;
        check({name, "_d50"}, clk_o50, exp50());
        check({name, "_d33"}, clk_o33, exp33());
    endtask

    // Pulse-shape monitors, active only during the long run.
    logic    mon_en;
    int      rises50, rises33, bad50, bad33;
    realtime rise50_t, rise33_t;
    logic    seen50, seen33;

    always @(posedge clk_o50) if (mon_en) begin
        if (seen50 && (($realtime - rise50_t) < 5.99 || ($realtime - rise50_t) > 6.01)) bad50++;
        rise50_t = $realtime;
        seen50   = 1'b1;
        rises50++;
    end
    always @(negedge clk_o50) if (mon_en && seen50) begin
        if (($realtime - rise50_t) < 2.99 || ($realtime - rise50_t) > 3.01) bad50++;
    end
    always @(posedge clk_o33) if (mon_en) begin
        if (seen33 && (($realtime - rise33_t) < 5.99 || ($realtime - rise33_t) > 6.01)) bad33++;
        rise33_t = $realtime;
        seen33   = 1'b1;
        rises33++;
    end
    always @(negedge clk_o33) if (mon_en && seen33) begin
        if (($realtime - rise33_t) < 1.99 || ($realtime - rise33_t) > 2.01) bad33++;
    end

    typedef struct {
        logic rst_v;
        logic e50;
        logic e33;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int   high50, high33, wait_cnt;
        logic held50, held33;

        tests   = 0;
        fails   = 0;
        mon_en  = 1'b0;
        rises50 = 0; rises33 = 0; bad50 = 0; bad33 = 0;
        seen50  = 1'b0; seen33 = 1'b0;
        rise50_t = 0.0; rise33_t = 0.0;

        // Each entry: drive rst at x.5, pass one clock edge, check at x.5.
        // Edges: 1r 2f (reset) 3r 4f 5r 6f 7r 8f 9r 10f 11r 12f 13r.
        vecs[0]  = '{1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        #0.5;
        check("reset_d50", clk_o50, 1'b0);
        check("reset_d33", clk_o33, 1'b0);

        for (int i = 0; i < 13; i++) begin
            rst = vecs[i].rst_v;
            #1;
            check($sformatf("vec%0d_d50", i), clk_o50, vecs[i].e50);
            check($sformatf("vec%0d_d33", i), clk_o33, vecs[i].e33);
        end

        // Mid-operation reset while the output is high must clear at once.
        rst = 1'b1;
        wait_cnt = 0;
        while (clk_o50 !== 1'b1 && wait_cnt < 10) begin
            #1;
            wait_cnt++;
        end
        check("wait_high", clk_o50, 1'b1);
        #0.2;
        rst = 1'b0;
        #0.1;
        check("async_rst_d50", clk_o50, 1'b0);
        check("async_rst_d33", clk_o33, 1'b0);
        #0.2;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) step_model("rerelease");

        // Stopped clock: outputs hold their value.
        clk_run = 1'b0;
        held50  = clk_o50;
        held33  = clk_o33;
        #10;
        check("hold_d50", clk_o50, held50);
        check("hold_d33", clk_o33, held33);
        clk_run = 1'b1;
        for (int i = 0; i < 6; i++) step_model("restart");

        // Random reset pulses and run lengths against the reference.
        for (int it = 0; it < 40; it++) begin
            int hold_n, run_n;
            hold_n = int'($urandom_range(1, 4));
            run_n  = int'($urandom_range(1, 24));
            rst = 1'b0;
            #0.1;
            check("rand_async_d50", clk_o50, 1'b0);
            check("rand_async_d33", clk_o33, 1'b0);
            #0.4;
            for (int k = 0; k < hold_n; k++) step_model("rand_hold");
            rst = 1'b1;
            for (int k = 0; k < run_n; k++) step_model("rand_run");
        end

        // Long run: 3000 input cycles after release.
        rst = 1'b0;
        #2;
        high50 = 0;
        high33 = 0;
        mon_en = 1'b1;
        rst    = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            step_model("long");
            if (clk_o50) high50++;
            if (clk_o33) high33++;
        end
        mon_en = 1'b0;
        check_int("long_rises_d50", rises50, 1000);
        check_int("long_rises_d33", rises33, 1000);
        check_int("long_high_d50", high50, 3000);
        check_int("long_high_d33", high33, 2000);
        check_int("long_shape_d50", bad50, 0);
        check_int("long_shape_d33", bad33, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_by_3.md
Name: clk_div_by_3

Overview:
Clock divider producing an output clock at one third of the input clock frequency.
Sits at the clock-generation layer and feeds logic or I/O that needs a slow derived clock.
Default output is 50% duty cycle, built from a rising-edge mod-3 counter plus a falling-edge retiming flop.
A parameter selects a simpler 1/3-duty, rising-edge-only output.

Parameters:
DUTY_50, default 1, meaning: 1 = 50% duty output (1.5 input periods high, 1.5 low); 0 = 1/3 duty output (1 input period high, 2 low).

Ports:
clk_i  input  1  input clock; all state is clocked by it (rising edge, plus falling edge for the DUTY_50 flop)
rst  input  1  asynchronous, active-low reset; deassertion must be synchronous to clk_i (upstream responsibility)
clk_o  output  1  divided clock, frequency = f(clk_i)/3

Behaviour:
- State:
  - cnt: 2-bit mod-3 counter on the rising edge of clk_i, sequence 0→1→2→0; value 3 unreachable, and if ever present it goes to 0 on the next edge.
  - p: rising-edge flop, p <= (cnt == 0).
  - n: falling-edge flop, n <= p. Exists only when DUTY_50=1; otherwise tied 0.
- clk_o = p | n when DUTY_50=1; clk_o = p when DUTY_50=0.
- Glitch-free requirement: p and n never change on the same edge, so the OR output must not glitch.
- clk_o is the only combinational term; no other logic is allowed on the output path.
- Reset (rst=0): cnt=0, p=0, n=0, clk_o=0 immediately, without waiting for a clock edge. This applies at any time, including mid-period. clk_o drops at once even if high.
- Timing after reset release (rising edges counted from the first edge after rst goes 1):
  - Edge 1: cnt 0→1, p=1, clk_o rises (clock-to-q latency, no extra cycle).
  - Following falling edge: n=1.
  - Edge 2: cnt=2, p=0; clk_o stays high via n.
  - Next falling edge: n=0, clk_o falls (DUTY_50=1). With DUTY_50=0, clk_o falls at edge 2.
  - Edge 3: cnt=0.
  - Edge 4: cnt=1, clk_o rises again.
- Period of clk_o: exactly 3 clk_i periods, steady state, no drift.
- High time: 1.5 input periods (DUTY_50=1) or 1 input period (DUTY_50=0).
- Phase: clk_o rising edges always coincide (plus clock-to-q) with clk_i rising edges where cnt transitions 0→1.
- If clk_i stops, clk_o holds its current value.
- No enable and no other inputs; the divider free-runs whenever rst=1.

Test Plan:
- Reset hold: clk_i period 2 ns, rst=0 for 4 ns → clk_o=0 throughout, cnt=0.
- Release with DUTY_50=1: rst=1, run 40 ns → first clk_o rise on the first clk_i rising edge after release. clk_o then rises every 6 ns, stays high 3 ns, and is low 3 ns.
- DUTY_50=0, same stimulus → clk_o period 6 ns, high 2 ns, rising on clk_i rising edges only.
- Mid-operation reset: drive rst=0 while clk_o=1 → clk_o=0 at once, with no clk edge needed. Re-release → same first-edge timing as the release scenario.
- Glitch check: sample clk_o at 10 ps resolution over 20 output periods → exactly one rise and one fall per 3 input periods, with no pulses shorter than 1 input half-period.
- Long run of 3000 input cycles → exactly 1000 clk_o rising edges, duty measured at 50% ±0 (DUTY_50=1).
